ras_predict: RTL and testbench
==============================

Name: ras_predict

Overview:
- Parametrised return-address stack for the Y86-64 pipeline's PC prediction path.
- Fetch pushes valP on `call` and pops a predicted target on `ret`, so the pipeline no longer stalls three bubbles per `ret`.
- Generalises the fixed-policy PC predictor with configurable depth/width, wrap-on-overflow, underflow detection, and checkpoint/restore of the stack pointer for jXX mispredict recovery.

Parameters:
ADDR_W, 64, width of a stored return address
DEPTH, 8, number of entries; power of two, >= 2
PTR_W, $clog2(DEPTH), width of the top-of-stack pointer

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
push_en  input  1  fetch decoded `call` this cycle
push_addr  input  ADDR_W  return address to push (f_valP of the `call`)
pop_en  input  1  fetch decoded `ret` this cycle
pred_addr  output  ADDR_W  current top-of-stack entry (combinational)
pred_valid  output  1  high when count != 0
ckpt_en  input  1  snapshot pointer/count (fetch of a conditional jXX)
restore_en  input  1  restore snapshot (jXX mispredict detected in execute)
count  output  PTR_W+1  valid entries, 0..DEPTH
full  output  1  count == DEPTH
overflow  output  1  sticky: a push overwrote the oldest entry
underflow  output  1  sticky: a pop occurred with count == 0

Behaviour:
- Storage: circular array mem[DEPTH] of ADDR_W bits, and a pointer tp.
  - tp addresses the next free slot; top entry = mem[tp-1] mod DEPTH.
- pred_addr = mem[(tp-1) mod DEPTH] at all times.
  - Zero-latency combinational read, so fetch selects the `ret` target in the same cycle.
  - Value is meaningful only when pred_valid = 1.
- Reset (synchronous, clk edge with reset = 1):
  - tp = 0, count = 0, shadow tp/count = 0, overflow = 0, underflow = 0, all mem entries = 0.
  - Outputs then read: pred_addr = 0, pred_valid = 0, full = 0.
  - Reset overrides every other input in the same cycle.
- Priority per cycle: reset > restore_en > push/pop > ckpt_en (ckpt_en samples the pre-update state).
- Push only:
  - mem[tp] <= push_addr; tp <= tp+1 mod DEPTH.
  - If count < DEPTH, count <= count+1.
  - If full, count stays DEPTH (oldest entry silently overwritten) and overflow <= 1.
- Pop only:
  - If count > 0: tp <= tp-1 mod DEPTH; count <= count-1. The popped value is the pred_addr shown during that cycle.
  - If count == 0: tp and count unchanged; underflow <= 1.
- Push and pop in the same cycle:
  - If count > 0: top entry is replaced, i.e. mem[tp-1] <= push_addr; tp and count unchanged.
  - If count == 0: treated as push only; underflow not set.
- ckpt_en: shadow_tp <= tp; shadow_count <= count. The shadow holds until the next ckpt_en or reset.
- restore_en:
  - tp <= shadow_tp; count <= shadow_count.
  - push_en/pop_en in that cycle are ignored, and a coincident ckpt_en is ignored.
  - mem contents are not restored; entries overwritten speculatively stay overwritten (accepted prediction loss).
- Sticky flags clear only on reset.
- No handshake back-pressure: every request is accepted in the cycle it is asserted.
- A wrong prediction is corrected downstream by the existing ret/mispredict logic.

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 on successive cycles → count=3, pred_addr=0x300; three pops yield 0x300, 0x200, 0x100, then pred_valid=0, count=0, underflow=0.
- DEPTH=8: push 0x10..0x90 (9 pushes) → count=8, full=1, overflow=1, pred_addr=0x90; 8 pops return 0x90..0x20, and 0x10 is never returned.
- Pop with count=0 → count stays 0, underflow=1 next cycle; push 0x40 then pop → 0x40 returned, underflow remains 1 until reset.
- With stack [0x100, 0x200]: simultaneous push 0x500 and pop → count=2, pred_addr=0x500; same stimulus on an empty stack → count=1, pred_addr=0x500, underflow=0.
- With stack [0x100, 0x200]: ckpt_en, then pop, pop, push 0x700, then restore_en with push_en=1 → count=2, tp back to its checkpoint value, push ignored, and the entry at the checkpointed top reads 0x200.
- Mid-sequence with count=5 and overflow=1, assert reset together with push_en → next cycle count=0, overflow=0, pred_valid=0, pred_addr=0.

Source files
------------

// File: rtl/ras_predict.sv
// Return-address stack for fetch-stage `ret` target prediction, with a circular store,
// sticky overflow/underflow flags and a pointer checkpoint for jXX mispredict recovery.
module ras_predict #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_en,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic              pop_en,
   output logic [ADDR_W-1:0] pred_addr,
   output logic              pred_valid,
   input  logic              ckpt_en,
   input  logic              restore_en,
   output logic [PTR_W:0]    count,
   output logic              full,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);
   localparam logic [PTR_W:0]   CntOne = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   CntMax = (PTR_W + 1)'(DEPTH);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  tp_q;
   logic [PTR_W-1:0]  shadow_tp_q;
   logic [PTR_W:0]    count_q;
   logic [PTR_W:0]    shadow_count_q;
   logic              overflow_q;
   logic              underflow_q;
   logic [PTR_W-1:0]  top_idx;
   logic              empty;

   // tp points at the next free slot, so the top entry sits one below it (mod DEPTH).
   assign top_idx    = tp_q - PtrOne;
   assign empty      = (count_q == '0);
   assign pred_addr  = mem[top_idx];
   assign pred_valid = !empty;
   assign full       = (count_q == CntMax);
   assign count      = count_q;
   assign overflow   = overflow_q;
   assign underflow  = underflow_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         tp_q           <= '0;
         count_q        <= '0;
         shadow_tp_q    <= '0;
         shadow_count_q <= '0;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (restore_en) begin
         // Memory is not rolled back; speculatively overwritten entries stay lost.
         tp_q    <= shadow_tp_q;
         count_q <= shadow_count_q;
      end else begin
         if (push_en && pop_en && !empty) begin
            mem[top_idx] <= push_addr;
         end else if (push_en) begin
            mem[tp_q] <= push_addr;
            tp_q      <= tp_q + PtrOne;
            if (full) begin
               overflow_q <= 1'b1;
            end else begin
               count_q <= count_q + CntOne;
            end
         end else if (pop_en) begin
            if (!empty) begin
               tp_q    <= top_idx;
               count_q <= count_q - CntOne;
            end else begin
               underflow_q <= 1'b1;
            end
         end
         // Snapshot takes the state as it was before this cycle's push/pop.
         if (ckpt_en) begin
            shadow_tp_q    <= tp_q;
            shadow_count_q <= count_q;
         end
      end
   end

endmodule

// File: tb/tb_ras_predict.sv
// Self-checking bench for ras_predict: directed scenarios followed by random traffic,
// all compared against an integer-arithmetic model of the stack rules.
module tb_ras_predict;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned PTR_W  = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              push_en;
   logic [ADDR_W-1:0] push_addr;
   logic              pop_en;
   logic [ADDR_W-1:0] pred_addr;
   logic              pred_valid;
   logic              ckpt_en;
   logic              restore_en;
   logic [PTR_W:0]    count;
   logic              full;
   logic              overflow;
   logic              underflow;

   int vectors     = 0;
   int miscompares = 0;

   logic [63:0] m_mem [DEPTH];
   int          m_tp, m_cnt, m_stp, m_scnt;
   bit          m_ovf, m_unf;

   ras_predict #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .push_en    (push_en),
      .push_addr  (push_addr),
      .pop_en     (pop_en),
      .pred_addr  (pred_addr),
      .pred_valid (pred_valid),
      .ckpt_en    (ckpt_en),
      .restore_en (restore_en),
      .count      (count),
      .full       (full),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_update(input bit rst, input bit ps, input logic [63:0] pa,
                               input bit pp, input bit ck, input bit rs);
      int tp0, cnt0;
      tp0  = m_tp;
      cnt0 = m_cnt;
      if (rst) begin
         m_tp = 0; m_cnt = 0; m_stp = 0; m_scnt = 0; m_ovf = 0; m_unf = 0;
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end else if (rs) begin
         m_tp  = m_stp;
         m_cnt = m_scnt;
      end else begin
         if (ps && pp && m_cnt > 0) begin
            m_mem[(m_tp + DEPTH - 1) % DEPTH] = pa;
         end else if (ps) begin
            m_mem[m_tp] = pa;
            m_tp = (m_tp + 1) % DEPTH;
            if (m_cnt == DEPTH) m_ovf = 1;
            else m_cnt++;
         end else if (pp) begin
            if (m_cnt > 0) begin
               m_tp = (m_tp + DEPTH - 1) % DEPTH;
               m_cnt--;
            end else begin
               m_unf = 1;
            end
         end
         if (ck) begin
            m_stp  = tp0;
            m_scnt = cnt0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".count"}, 64'(count), 64'(m_cnt));
      chk({tag, ".full"}, 64'(full), 64'(m_cnt == DEPTH));
      chk({tag, ".valid"}, 64'(pred_valid), 64'(m_cnt != 0));
      chk({tag, ".pred"}, pred_addr, m_mem[(m_tp + DEPTH - 1) % DEPTH]);
      chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
      chk({tag, ".unf"}, 64'(underflow), 64'(m_unf));
   endtask

   task automatic step(input string tag, input bit rst, input bit ps, input logic [63:0] pa,
                       input bit pp, input bit ck, input bit rs);
      reset = rst; push_en = ps; push_addr = pa; pop_en = pp; ckpt_en = ck; restore_en = rs;
      @(posedge clk);
      model_update(rst, ps, pa, pp, ck, rs);
      @(negedge clk);
      reset = 0; push_en = 0; pop_en = 0; ckpt_en = 0; restore_en = 0;
      check_all(tag);
   endtask

   task automatic do_reset();
      step("reset", 1, 0, 0, 0, 0, 0);
   endtask

   task automatic push(input logic [63:0] a);
      step("push", 0, 1, a, 0, 0, 0);
   endtask

   task automatic pop();
      step("pop", 0, 0, 0, 1, 0, 0);
   endtask

   initial begin
      reset = 1; push_en = 0; push_addr = '0; pop_en = 0; ckpt_en = 0; restore_en = 0;
      @(negedge clk);
      do_reset();
      chk("rst.count", 64'(count), 0);
      chk("rst.pred", pred_addr, 0);

      // Basic LIFO order
      push(64'h100); push(64'h200); push(64'h300);
      chk("lifo.count", 64'(count), 3);
      chk("lifo.top", pred_addr, 64'h300);
      chk("lifo.pop1", pred_addr, 64'h300); pop();
      chk("lifo.pop2", pred_addr, 64'h200); pop();
      chk("lifo.pop3", pred_addr, 64'h100); pop();
      chk("lifo.valid", 64'(pred_valid), 0);
      chk("lifo.unf", 64'(underflow), 0);

      // Overflow wraps onto the oldest entry
      do_reset();
      for (int i = 1; i <= 9; i++) push(64'(i * 16));
      chk("ovf.count", 64'(count), 8);
      chk("ovf.full", 64'(full), 1);
      chk("ovf.flag", 64'(overflow), 1);
      for (int i = 9; i >= 2; i--) begin
         chk("ovf.popval", pred_addr, 64'(i * 16));
         pop();
      end
      chk("ovf.empty", 64'(count), 0);

      // Underflow is sticky
      pop();
      chk("unf.flag", 64'(underflow), 1);
      chk("unf.count", 64'(count), 0);
      push(64'h40);
      chk("unf.popval", pred_addr, 64'h40);
      pop();
      chk("unf.sticky", 64'(underflow), 1);

      // Simultaneous push and pop
      do_reset();
      push(64'h100); push(64'h200);
      step("pushpop", 0, 1, 64'h500, 1, 0, 0);
      chk("pp.count", 64'(count), 2);
      chk("pp.top", pred_addr, 64'h500);
      do_reset();
      step("pushpop_empty", 0, 1, 64'h500, 1, 0, 0);
      chk("ppe.count", 64'(count), 1);
      chk("ppe.top", pred_addr, 64'h500);
      chk("ppe.unf", 64'(underflow), 0);

      // Checkpoint and restore
      do_reset();
      push(64'h100); push(64'h200);
      step("ckpt", 0, 0, 0, 0, 1, 0);
      pop(); pop(); push(64'h700);
      step("restore", 0, 1, 64'hdead, 0, 0, 1);
      chk("rest.count", 64'(count), 2);
      chk("rest.top", pred_addr, 64'h200);

      // Reset beats a coincident push
      do_reset();
      for (int i = 1; i <= 9; i++) push(64'(i));
      pop(); pop(); pop();
      chk("mid.count", 64'(count), 5);
      chk("mid.ovf", 64'(overflow), 1);
      step("rst_push", 1, 1, 64'h1234, 0, 0, 0);
      chk("rp.count", 64'(count), 0);
      chk("rp.ovf", 64'(overflow), 0);
      chk("rp.valid", 64'(pred_valid), 0);
      chk("rp.pred", pred_addr, 0);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         bit r_rst, r_ps, r_pp, r_ck, r_rs;
         r_rst = ($urandom_range(0, 99) < 2);
         r_ps  = ($urandom_range(0, 99) < 50);
         r_pp  = ($urandom_range(0, 99) < 45);
         r_ck  = ($urandom_range(0, 99) < 15);
         r_rs  = ($urandom_range(0, 99) < 8);
         step("rand", r_rst, r_ps, {$urandom, $urandom}, r_pp, r_ck, r_rs);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
